// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA HOLD/HOLD_ACK arbiter.
// Holds the arbiter state encoding, default bus widths and the word-alignment check.
package dma_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0]  ALIGN_MASK = 2'b11;
    localparam logic [15:0] WORDS_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_GRANT,
        ST_RELEASE
    } arb_state_t;

    function automatic logic is_aligned(input logic [1:0] lsbs);
        return (lsbs & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/hold_watchdog.sv
// Hold-duration watchdog: counts grant cycles from grant entry and raises a sticky
// flag once the count reaches HOLD_LIMIT. The grant itself is never revoked.
module hold_watchdog
    import dma_arb_pkg::*;
#(
    parameter int HOLD_LIMIT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic clear,
    output logic timeout
);

    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_LIMIT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] count;
    logic             reach;

    // The flag fires once, on the cycle the count steps onto the limit.
    assign reach = active && (count == LIMIT - ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (active && (count != LIMIT)) begin
            count <= count + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if (reach) begin
            timeout <= 1'b1;
        end else if (clear) begin
            timeout <= 1'b0;
        end
    end

endmodule

// File: rtl/dma_hold_arbiter.sv
// Data-memory port owner: stalls and drains the CPU on a coprocessor HOLD, then hands
// the port to the DMA master until HOLD drops, with write counting and alignment checks.
module dma_hold_arbiter
    import dma_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DRAIN_CYCLES = 2,
    parameter int HOLD_LIMIT   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HOLD,
    output logic              HOLD_ACK,
    output logic              cpu_stall,
    input  logic              cpu_mem_busy,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wd,
    output logic [DATA_W-1:0] dma_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [15:0]       dma_words,
    output logic              hold_timeout,
    output logic              align_err,
    input  logic              status_clr
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
    localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

    arb_state_t     state;
    arb_state_t     next_state;
    logic [DCW-1:0] drain_cnt;
    logic [DCW-1:0] drain_next;
    logic           sel_dma;
    logic           dma_wr_ok;
    logic           dma_wr_bad;
    logic           grant_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            HOLD_ACK  <= 1'b0;
            cpu_stall <= 1'b0;
        end else begin
            state     <= next_state;
            drain_cnt <= drain_next;
            HOLD_ACK  <= (next_state == ST_GRANT);
            cpu_stall <= (next_state != ST_IDLE);
        end
    end

    // A HOLD drop during DRAIN aborts even on the cycle the grant would have fired.
    always_comb begin
        next_state = state;
        drain_next = drain_cnt;
        case (state)
            ST_IDLE: begin
                if (HOLD) begin
                    next_state = ST_DRAIN;
                    drain_next = '0;
                end
            end
            ST_DRAIN: begin
                if (!HOLD) begin
                    next_state = ST_IDLE;
                end else if (cpu_mem_busy) begin
                    drain_next = '0;
                end else if (drain_cnt == DRAIN_LAST) begin
                    next_state = ST_GRANT;
                end else begin
                    drain_next = drain_cnt + DRAIN_ONE;
                end
            end
            ST_GRANT: begin
                if (!HOLD) begin
                    next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign grant_start = (state == ST_DRAIN) && (next_state == ST_GRANT);
    assign sel_dma     = (state == ST_GRANT);
    assign dma_wr_ok   = sel_dma && dma_we && is_aligned(dma_addr[1:0]);
    assign dma_wr_bad  = sel_dma && dma_we && !is_aligned(dma_addr[1:0]);

    // RELEASE keeps the mux on the CPU but blocks writes from both masters.
    always_comb begin
        mem_addr = sel_dma ? dma_addr : cpu_addr;
        mem_wd   = sel_dma ? dma_wd : cpu_wd;
        mem_we   = sel_dma ? dma_wr_ok
                           : (cpu_we && ((state == ST_IDLE) || (state == ST_DRAIN)));
        cpu_rd   = mem_rd;
        dma_rd   = sel_dma ? mem_rd : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dma_words <= '0;
        end else if (grant_start) begin
            dma_words <= '0;
        end else if (dma_wr_ok && (dma_words != WORDS_MAX)) begin
            dma_words <= dma_words + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            align_err <= 1'b0;
        end else if (dma_wr_bad) begin
            align_err <= 1'b1;
        end else if (status_clr) begin
            align_err <= 1'b0;
        end
    end

    hold_watchdog #(
        .HOLD_LIMIT(HOLD_LIMIT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (grant_start),
        .active (sel_dma),
        .clear  (status_clr),
        .timeout(hold_timeout)
    );

endmodule

// File: tb/tb_dma_hold_arbiter.sv
// Randomized bench for dma_hold_arbiter: a driver issues HOLD sessions and memory traffic,
// queuing the writes memory should see; a monitor pops them whenever mem_we is raised.
module tb_dma_hold_arbiter;

    localparam int DRAIN = 2;
    localparam int LIMIT = 16;
    localparam int P_CPU = 0;
    localparam int P_DMA = 1;
    localparam int P_REL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        HOLD;
    logic        HOLD_ACK;
    logic        cpu_stall;
    logic        cpu_mem_busy;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wd;
    logic [31:0] dma_rd;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [15:0] dma_words;
    logic        hold_timeout;
    logic        align_err;
    logic        status_clr;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
    } wr_t;

    wr_t  expQ[$];
    int   checks = 0;
    int   errors = 0;
    logic expAlign;
    logic expTimeout;
    int   expWords;
    logic pendAlign;
    logic pendTime;
    logic pendClr;

    dma_hold_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DRAIN_CYCLES(DRAIN),
        .HOLD_LIMIT  (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .HOLD        (HOLD),
        .HOLD_ACK    (HOLD_ACK),
        .cpu_stall   (cpu_stall),
        .cpu_mem_busy(cpu_mem_busy),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wd      (cpu_wd),
        .cpu_rd      (cpu_rd),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wd      (dma_wd),
        .dma_rd      (dma_rd),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wd      (mem_wd),
        .mem_rd      (mem_rd),
        .dma_words   (dma_words),
        .hold_timeout(hold_timeout),
        .align_err   (align_err),
        .status_clr  (status_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge and fold in the sticky-flag events that edge sampled; set wins over clear.
    task automatic stepCycle();
        @(posedge clk);
        if (pendAlign)    expAlign = 1'b1;
        else if (pendClr) expAlign = 1'b0;
        if (pendTime)     expTimeout = 1'b1;
        else if (pendClr) expTimeout = 1'b0;
        pendAlign = 1'b0;
        pendTime  = 1'b0;
        pendClr   = 1'b0;
        #1;
    endtask

    task automatic checkRegs(input logic ack, input logic stall);
        checkOutput("hold_ack", {31'b0, HOLD_ACK}, {31'b0, ack});
        checkOutput("cpu_stall", {31'b0, cpu_stall}, {31'b0, stall});
        checkOutput("align_err", {31'b0, align_err}, {31'b0, expAlign});
        checkOutput("hold_timeout", {31'b0, hold_timeout}, {31'b0, expTimeout});
    endtask

    // path says which master owns memory this cycle (CPU, DMA, or nobody during turnaround).
    task automatic applyStimulus(input int path, input logic hold, input logic busy,
                                 input logic dmaWe, input logic [31:0] dAddr, input logic clr);
        wr_t w;
        HOLD         = hold;
        cpu_mem_busy = busy;
        cpu_we       = ($urandom_range(1) == 1);
        cpu_addr     = $urandom();
        cpu_wd       = $urandom();
        dma_we       = dmaWe;
        dma_addr     = dAddr;
        dma_wd       = $urandom();
        mem_rd       = $urandom();
        status_clr   = clr;
        pendClr      = clr;
        if (path == P_CPU && cpu_we) begin
            w.addr = cpu_addr;
            w.wd   = cpu_wd;
            expQ.push_back(w);
        end
        if (path == P_DMA && dmaWe) begin
            if (dAddr[1:0] == 2'b00) begin
                w.addr = dAddr;
                w.wd   = dma_wd;
                expQ.push_back(w);
                expWords++;
            end else begin
                pendAlign = 1'b1;
            end
        end
        #1;
        checkOutput("mem_addr", mem_addr, (path == P_DMA) ? dma_addr : cpu_addr);
        checkOutput("cpu_rd", cpu_rd, mem_rd);
        checkOutput("dma_rd", dma_rd, (path == P_DMA) ? mem_rd : 32'h0);
        if (path == P_REL) checkOutput("release_we", {31'b0, mem_we}, 32'h0);
    endtask

    function automatic logic [31:0] randDmaAddr();
        logic [31:0] a;
        a = $urandom() & 32'hFFFF_FFFC;
        if ($urandom_range(3) == 0) a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    // One HOLD session: idle traffic, request, drain (random busy / abort), grant, release.
    task automatic runSession(input bit doReset);
        logic b[16];
        int   e;
        int   run;
        int   abortAt;
        int   m;
        logic dWe;
        logic clr;
        run = 0;
        e   = 0;
        for (int i = 0; i < 16; i++) b[i] = (i >= 1) && (i < 8) && ($urandom_range(3) == 0);
        for (int i = 1; i < 16; i++) begin
            if (b[i]) run = 0;
            else run++;
            if (run >= DRAIN && e == 0) e = i;
        end
        abortAt = (!doReset && $urandom_range(4) == 0) ? $urandom_range(1, e) : 0;
        m       = doReset ? 10 : $urandom_range(1, 22);

        for (int i = 0; i < $urandom_range(1, 4); i++) begin
            stepCycle();
            checkRegs(1'b0, 1'b0);
            applyStimulus(P_CPU, 1'b0, $urandom_range(1) == 1, $urandom_range(1) == 1,
                          randDmaAddr(), $urandom_range(5) == 0);
        end
        stepCycle();
        checkRegs(1'b0, 1'b0);
        applyStimulus(P_CPU, 1'b1, $urandom_range(1) == 1, 1'b0, randDmaAddr(), 1'b0);

        for (int i = 1; i <= e; i++) begin
            stepCycle();
            checkRegs(1'b0, 1'b1);
            checkOutput("drain_rd", dma_rd, 32'h0);
            if (i == abortAt) begin
                applyStimulus(P_CPU, 1'b0, b[i], 1'b0, randDmaAddr(), 1'b0);
                stepCycle();
                checkRegs(1'b0, 1'b0);
                applyStimulus(P_CPU, 1'b0, 1'b0, 1'b0, randDmaAddr(), 1'b0);
                return;
            end
            applyStimulus(P_CPU, 1'b1, b[i], 1'b0, randDmaAddr(), $urandom_range(5) == 0);
        end

        expWords = 0;
        for (int g = 1; g <= m; g++) begin
            stepCycle();
            checkRegs(1'b1, 1'b1);
            if (g == 1) checkOutput("words_clr", {16'b0, dma_words}, 32'h0);
            if (doReset && g == 3) begin
                HOLD       = 1'b1;
                cpu_we     = 1'b0;
                dma_we     = 1'b0;
                status_clr = 1'b0;
                rst        = 1'b1;
                stepCycle();
                rst        = 1'b0;
                expAlign   = 1'b0;
                expTimeout = 1'b0;
                expWords   = 0;
                checkRegs(1'b0, 1'b0);
                checkOutput("reset_words", {16'b0, dma_words}, 32'h0);
                applyStimulus(P_CPU, 1'b0, 1'b0, 1'b0, randDmaAddr(), 1'b0);
                return;
            end
            dWe = ($urandom_range(4) < 3);
            clr = (g <= LIMIT) && ($urandom_range(7) == 0);
            pendTime = (g == LIMIT);
            applyStimulus(P_DMA, g < m, $urandom_range(1) == 1, dWe, randDmaAddr(), clr);
        end

        stepCycle();
        checkRegs(1'b0, 1'b1);
        checkOutput("dma_words", {16'b0, dma_words}, 32'(expWords));
        applyStimulus(P_REL, $urandom_range(1) == 1, 1'b0, $urandom_range(1) == 1,
                      randDmaAddr(), $urandom_range(5) == 0);
    endtask

    // Scoreboard monitor: every memory write must match the oldest queued expectation.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst && mem_we) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none at %0t",
                             mem_addr, mem_wd, $time);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("sb_addr", mem_addr, w.addr);
                    checkOutput("sb_data", mem_wd, w.wd);
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        HOLD         = 1'b0;
        cpu_mem_busy = 1'b0;
        cpu_we       = 1'b0;
        cpu_addr     = '0;
        cpu_wd       = '0;
        dma_we       = 1'b0;
        dma_addr     = '0;
        dma_wd       = '0;
        mem_rd       = '0;
        status_clr   = 1'b0;
        expAlign     = 1'b0;
        expTimeout   = 1'b0;
        expWords     = 0;
        pendAlign    = 1'b0;
        pendTime     = 1'b0;
        pendClr      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkRegs(1'b0, 1'b0);
        checkOutput("reset_words", {16'b0, dma_words}, 32'h0);
        rst = 1'b0;

        for (int s = 0; s < 60; s++) runSession(1'b0);
        runSession(1'b1);
        for (int s = 0; s < 5; s++) runSession(1'b0);

        stepCycle();
        applyStimulus(P_CPU, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        stepCycle();
        checkOutput("sb_drained", 32'(expQ.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_hold_arbiter.md
# dma_hold_arbiter

Memory-side responder for the coprocessor DMA HOLD/HOLD_ACK handshake. It owns the single data-memory port. On a coprocessor HOLD it stalls the CPU, drains any in-flight CPU access, grants HOLD_ACK, and multiplexes the DMA master onto memory until HOLD drops. It sits between the CPU MEM stage, the CP2 DMA port and data memory, and adds a hold watchdog, write counting and alignment checking.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DRAIN_CYCLES, 2, minimum consecutive non-busy cycles in DRAIN before grant (≥1)
- HOLD_LIMIT, 4096, grant-cycle count that sets hold_timeout
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- HOLD  in  1  DMA bus request
- HOLD_ACK  out  1  bus granted (registered)
- cpu_stall  out  1  freeze CPU pipeline (registered)
- cpu_mem_busy  in  1  CPU has an access in its MEM stage
- cpu_we, cpu_addr, cpu_wd  in  1/ADDR_W/DATA_W  CPU memory request
- cpu_rd  out  DATA_W  = mem_rd
- dma_we, dma_addr, dma_wd  in  1/ADDR_W/DATA_W  DMA memory request
- dma_rd  out  DATA_W  mem_rd in GRANT, else 0
- mem_we, mem_addr, mem_wd  out  1/ADDR_W/DATA_W  to data memory (async read)
- mem_rd  in  DATA_W  memory read data
- dma_words  out  16  DMA writes accepted in current/last grant
- hold_timeout  out  1  sticky watchdog flag
- align_err  out  1  sticky misaligned DMA write flag
- status_clr  in  1  clears both sticky flags

## Operation
- States: IDLE, DRAIN, GRANT, RELEASE. HOLD_ACK=1 only in GRANT. cpu_stall=1 in DRAIN, GRANT and RELEASE.
- IDLE: memory mux selects CPU. HOLD=1 → DRAIN with drain_cnt=0.
- DRAIN: mux stays on CPU so an in-flight access completes.
  - cpu_mem_busy=1 → drain_cnt=0.
  - Otherwise drain_cnt increments.
  - busy=0 and drain_cnt==DRAIN_CYCLES-1 → GRANT; on entry dma_words=0 and hold_cnt=0.
  - HOLD=0 → IDLE. This abort has priority over the grant.
- GRANT: mux selects DMA.
  - mem_we = dma_we & (dma_addr[1:0]==0).
  - An accepted write increments dma_words, saturating at 0xFFFF.
  - dma_we with nonzero dma_addr[1:0] suppresses the write and sets align_err.
  - hold_cnt increments per cycle; reaching HOLD_LIMIT sets hold_timeout. The grant is not revoked.
  - HOLD=0 → RELEASE.
- RELEASE: one turnaround cycle with mem_we=0 and mux on CPU. HOLD is ignored here; the state always goes to IDLE, which samples HOLD on the next edge.
- Sticky flags: status_clr clears them. A set condition in the same cycle wins.
- mem_addr and mem_wd follow the selected master combinationally. mem_we also requires the state to be IDLE/DRAIN (CPU) or GRANT (DMA).

## Timing
- Reset values: state IDLE, HOLD_ACK 0, cpu_stall 0, dma_words 0, hold_timeout 0, align_err 0, counters 0. Reset mid-grant drops HOLD_ACK at the next edge.
- With HOLD sampled high at edge k and busy low:
  - DRAIN occupies k+1..k+DRAIN_CYCLES.
  - HOLD_ACK rises at edge k+DRAIN_CYCLES+1 (default: 3 edges).
  - Each busy cycle adds one cycle plus the restart of the DRAIN_CYCLES count.
- HOLD low sampled in GRANT: HOLD_ACK falls next edge (RELEASE). cpu_stall falls one edge later.
- Memory path is combinational: DMA read data is valid in the same cycle as dma_addr.

## Structure
- Package dma_arb_pkg: state enum, ADDR_W/DATA_W defaults, alignment mask constant.
- Sub-module hold_watchdog: counter with clear-on-grant-entry and sticky terminal-count flag, parameterised by HOLD_LIMIT.
- Top level: FSM, mux, write counter, align check.

## Test plan
- Basic grant: HOLD=1 at edge 5, busy=0 → cpu_stall=1 from edge 6, HOLD_ACK=1 from edge 8. dma_we=1, addr 0x100, wd 0xDEADBEEF → mem_we=1, mem_addr=0x100, mem_wd=0xDEADBEEF.
- Drain extension: busy=1 for 3 cycles starting at edge 6 → HOLD_ACK rises at edge 11. cpu_we=1 during DRAIN reaches memory.
- Abort/release: HOLD drops at edge 7 → IDLE at 8, HOLD_ACK never rises. Separately, HOLD drop in GRANT → one cycle with HOLD_ACK=0, mem_we=0, cpu_stall=1, then cpu_stall=0.
- Watchdog (HOLD_LIMIT=16): hold 20 cycles → hold_timeout=1 after the 16th grant cycle. It stays 1 through release and clears on status_clr.
- Alignment/count: four writes to 0x200, 0x204, 0x208, 0x20C plus one to 0x202 → mem_we low for 0x202, align_err=1, dma_words=4.
- Reset mid-grant: rst during GRANT → next edge HOLD_ACK=0, cpu_stall=0, dma_words=0.
